// File: rtl/plt_pkg.sv
// Shared definitions for the programmable LUT tree configuration loader.
// Verify states exist only when PLT_LOADER_READBACK_EN is defined.
package plt_pkg;

    localparam logic [1:0] PLT_MODE_CFG  = 2'b00;
    localparam logic [1:0] PLT_MODE_USE  = 2'b01;
    localparam logic [1:0] PLT_MODE_TEST = 2'b10;
    localparam logic [1:0] PLT_MODE_HOLD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SHIFT,
        ST_COMMIT,
        ST_SCAN,
`ifdef PLT_LOADER_READBACK_EN
        ST_VERIFY_REQ,
        ST_VERIFY_CHK,
`endif
        ST_RUN
    } plt_state_t;

    // Each of the N-1 two-input LUTs takes a 4-bit truth table.
    function automatic int unsigned plt_cfg_width(input int unsigned n);
        return 4 * (n - 1);
    endfunction

endpackage

// File: rtl/plt_cfg_serializer.sv
// Shadow register for the configuration word: parallel load, MSB-first
// left shift, and a bit counter flagging the final shift cycle.
module plt_cfg_serializer #(
    parameter int unsigned W = 28
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift,
    output logic [W-1:0] data,
    output logic         msb,
    output logic         last
);

    localparam int unsigned   CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            cnt  <= '0;
        end else if (load) begin
            data <= load_data;
            cnt  <= '0;
        end else if (shift) begin
            data <= {data[W-2:0], 1'b0};
            cnt  <= cnt + 1'b1;
        end
    end

    assign msb  = data[W-1];
    assign last = (cnt == LAST);

endmodule

// File: rtl/plt_config_loader.sv
// Loads a configuration word into the LUT tree over its serial or scan path.
// Optional readback check is enabled by defining PLT_LOADER_READBACK_EN.
module plt_config_loader
    import plt_pkg::*;
#(
    parameter  int unsigned N = 8,
    localparam int unsigned W = plt_cfg_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_data,
    input  logic         cfg_scan,
    output logic [1:0]   plt_mode,
    output logic         plt_clear,
    output logic         plt_config_in,
    output logic [W-1:0] plt_scan_in,
    output logic         plt_scan_enable,
    output logic         busy,
`ifdef PLT_LOADER_READBACK_EN
    input  logic [W-1:0] plt_scan_out,
    output logic         verify_err,
`endif
    output logic         done
);

    plt_state_t   state, next_state;
    logic         accept;
    logic         scan_sel;
    logic [W-1:0] ser_data;
    logic         ser_msb;
    logic         ser_last;

    assign accept = cfg_valid && cfg_ready;

    plt_cfg_serializer #(
        .W(W)
    ) u_serializer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_data(cfg_data),
        .shift    (state == ST_SHIFT),
        .data     (ser_data),
        .msb      (ser_msb),
        .last     (ser_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            scan_sel <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= next_state;
            done  <= (next_state == ST_RUN) && (state != ST_RUN);
            if (accept) scan_sel <= cfg_scan;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (accept) next_state = ST_CLEAR;
            ST_CLEAR:  next_state = scan_sel ? ST_SCAN : ST_SHIFT;
            ST_SHIFT:  if (ser_last) next_state = ST_COMMIT;
`ifdef PLT_LOADER_READBACK_EN
            ST_COMMIT,
            ST_SCAN:       next_state = ST_VERIFY_REQ;
            ST_VERIFY_REQ: next_state = ST_VERIFY_CHK;
            ST_VERIFY_CHK: next_state = ST_RUN;
`else
            ST_COMMIT,
            ST_SCAN:   next_state = ST_RUN;
`endif
            ST_RUN:    if (accept) next_state = ST_CLEAR;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready       = 1'b0;
        plt_mode        = PLT_MODE_HOLD;
        plt_clear       = 1'b0;
        plt_config_in   = 1'b0;
        plt_scan_in     = '0;
        plt_scan_enable = 1'b0;
        busy            = 1'b0;
        case (state)
            ST_IDLE:   cfg_ready = 1'b1;
            ST_CLEAR: begin
                plt_clear = 1'b1;
                busy      = 1'b1;
            end
            ST_SHIFT: begin
                plt_mode      = PLT_MODE_CFG;
                plt_config_in = ser_msb;
                busy          = 1'b1;
            end
            ST_COMMIT: begin
                plt_mode = PLT_MODE_CFG;
                busy     = 1'b1;
            end
            ST_SCAN: begin
                plt_mode        = PLT_MODE_CFG;
                plt_scan_enable = 1'b1;
                plt_scan_in     = ser_data;
                busy            = 1'b1;
            end
`ifdef PLT_LOADER_READBACK_EN
            ST_VERIFY_REQ: begin
                plt_mode        = PLT_MODE_TEST;
                plt_scan_enable = 1'b1;
                busy            = 1'b1;
            end
            ST_VERIFY_CHK: begin
                plt_mode = PLT_MODE_TEST;
                busy     = 1'b1;
            end
`endif
            ST_RUN: begin
                plt_mode  = PLT_MODE_USE;
                cfg_ready = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef PLT_LOADER_READBACK_EN
    // The shadow is consumed by the serial shift, so the readback target is
    // captured separately: the tree's shift register ends one bit past the word.
    logic [W-1:0] verify_exp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            verify_err <= 1'b0;
            verify_exp <= '0;
        end else if (accept) begin
            verify_err <= 1'b0;
            verify_exp <= cfg_scan ? cfg_data : {cfg_data[W-2:0], 1'b0};
        end else if (state == ST_VERIFY_CHK) begin
            verify_err <= (plt_scan_out != verify_exp);
        end
    end
`endif

endmodule

// File: tb/tb_plt_config_loader.sv
// Self-checking bench for plt_config_loader with a behavioural LUT tree model.
// Also exercises readback when compiled with PLT_LOADER_READBACK_EN.
module tb_plt_config_loader;

    localparam int unsigned N = 8;
    localparam int unsigned W = 4 * (N - 1);
`ifdef PLT_LOADER_READBACK_EN
    localparam int unsigned XL = 2;
`else
    localparam int unsigned XL = 0;
`endif
    localparam int LSER  = W + 3 + XL;
    localparam int LSCAN = 3 + XL;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [W-1:0] cfg_data = '0;
    logic         cfg_scan = 1'b0;
    logic [1:0]   plt_mode;
    logic         plt_clear;
    logic         plt_config_in;
    logic [W-1:0] plt_scan_in;
    logic         plt_scan_enable;
    logic         busy;
    logic         done;

    // Behavioural tree: shift register plus LUT storage
    logic [W-1:0] tree_sr  = '0;
    logic [W-1:0] tree_lut = '0;
    logic         stuck5   = 1'b0;

`ifdef PLT_LOADER_READBACK_EN
    logic         verify_err;
    logic [W-1:0] plt_scan_out;
    logic         ve_trace [0:63];
    assign plt_scan_out = stuck5 ? (tree_sr | (W'(1) << 5)) : tree_sr;
`endif

    plt_config_loader #(.N(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_data       (cfg_data),
        .cfg_scan       (cfg_scan),
        .plt_mode       (plt_mode),
        .plt_clear      (plt_clear),
        .plt_config_in  (plt_config_in),
        .plt_scan_in    (plt_scan_in),
        .plt_scan_enable(plt_scan_enable),
        .busy           (busy),
`ifdef PLT_LOADER_READBACK_EN
        .plt_scan_out   (plt_scan_out),
        .verify_err     (verify_err),
`endif
        .done           (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (plt_clear) begin
            tree_sr  <= '0;
            tree_lut <= '0;
        end else if (plt_mode == 2'b00) begin
            if (plt_scan_enable) begin
                tree_sr  <= plt_scan_in;
                tree_lut <= plt_scan_in;
            end else begin
                tree_sr  <= {tree_sr[W-2:0], plt_config_in};
                tree_lut <= tree_sr;
            end
        end
    end

    int tests = 0;
    int fails = 0;
    logic [7:0]   trace      [0:63];
    logic [W-1:0] scan_trace [0:63];

    function automatic logic [7:0] obs();
        return {plt_mode, plt_clear, plt_config_in, plt_scan_enable, busy, done, cfg_ready};
    endfunction

    // Expected control vector in cycle c after the accept edge
    function automatic logic [7:0] exp_ctrl(input int c, input logic [W-1:0] d, input logic s);
        logic [1:0] m;
        logic clr, ci, se, bsy, dn, rdy;
        int L;
        m = 2'b11; clr = 0; ci = 0; se = 0; bsy = 0; dn = 0; rdy = 0;
        L = s ? LSCAN : LSER;
        if (c == L) begin
            m = 2'b01; dn = 1; rdy = 1;
        end else if (c > L) begin
            m = 2'b01; rdy = 1;
        end else if (c == 1) begin
            clr = 1; bsy = 1;
        end else begin
            m = 2'b00; bsy = 1;
            if (!s && c <= W + 1) ci = d[W + 1 - c];
            else if (s && c == 2) se = 1;
            else if (XL != 0 && c == L - 2) begin m = 2'b10; se = 1; end
            else if (XL != 0 && c == L - 1) m = 2'b10;
        end
        return {m, clr, ci, se, bsy, dn, rdy};
    endfunction

    function automatic logic tree_eval(input logic [W-1:0] lut, input logic [N-1:0] din);
        logic [2*N-2:0] v;
        logic [3:0] nib;
        v = '0;
        v[N-1:0] = din;
        for (int unsigned i = 0; i < N - 1; i++) begin
            nib = lut[4*i +: 4];
            v[N+i] = nib[{v[2*i+1], v[2*i]}];
        end
        return v[2*N-2];
    endfunction

    task automatic run_load(input logic [W-1:0] d, input logic s, input logic [W-1:0] next_d,
                            input logic hold_next, input int ncyc, output int waited);
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_scan  = s;
        waited    = 0;
        while (!cfg_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        if (hold_next) cfg_data = next_d;
        else cfg_valid = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            trace[c]      = obs();
            scan_trace[c] = plt_scan_in;
`ifdef PLT_LOADER_READBACK_EN
            ve_trace[c]   = verify_err;
`endif
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        int w, bad;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        v = obs();
        tests++;
        if (v[7:1] !== 7'b1100000) begin
            fails++; $display("FAIL reset_hold got %b want %b", v[7:1], 7'b1100000);
        end
        rst_n = 1'b1;
        @(negedge clk);
        v = obs();
        tests++;
        if (v !== 8'b11000001) begin
            fails++; $display("FAIL reset_release got %b want %b", v, 8'b11000001);
        end
        run_load(28'h96A5C3F, 1'b0, '0, 1'b0, 12, w);
        tests++;
        if (trace[12] !== exp_ctrl(12, 28'h96A5C3F, 1'b0) || w > 0) begin
            fails++; $display("FAIL abort_pre got %b want %b", trace[12], exp_ctrl(12, 28'h96A5C3F, 1'b0));
        end
        #2 rst_n = 1'b0;
        #1 v = obs();
        tests++;
        if (v[7:1] !== 7'b1100000 || plt_scan_in !== '0) begin
            fails++; $display("FAIL abort_async got %b want %b", v[7:1], 7'b1100000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            v = obs();
            if (v !== 8'b11000001) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++; $display("FAIL abort_quiet got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_serial_fixed();
        logic [W-1:0] d;
        int w;
        d = 28'h96A5C3F;
        run_load(d, 1'b0, '0, 1'b0, LSER + 2, w);
        for (int c = 1; c <= LSER + 2; c++) begin
            tests++;
            if (trace[c] !== exp_ctrl(c, d, 1'b0)) begin
                fails++; $display("FAIL serial_cycle %0d got %b want %b", c, trace[c], exp_ctrl(c, d, 1'b0));
            end
        end
        tests++;
        if (tree_lut !== d) begin
            fails++; $display("FAIL serial_tree got %h want %h", tree_lut, d);
        end
    endtask

    task automatic test_e2e_and();
        int w;
        run_load(28'h8888888, 1'b0, '0, 1'b0, LSER + 1, w);
        tests++;
        if (tree_eval(tree_lut, 8'hFF) !== 1'b1) begin
            fails++; $display("FAIL and_ff got %b want 1", tree_eval(tree_lut, 8'hFF));
        end
        tests++;
        if (tree_eval(tree_lut, 8'hFE) !== 1'b0) begin
            fails++; $display("FAIL and_fe got %b want 0", tree_eval(tree_lut, 8'hFE));
        end
    endtask

    task automatic test_scan_xor();
        logic [W-1:0] d;
        int w;
        d = 28'h6666666;
        run_load(d, 1'b1, '0, 1'b0, LSCAN + 1, w);
        for (int c = 1; c <= LSCAN + 1; c++) begin
            tests++;
            if (trace[c] !== exp_ctrl(c, d, 1'b1)) begin
                fails++; $display("FAIL scan_cycle %0d got %b want %b", c, trace[c], exp_ctrl(c, d, 1'b1));
            end
        end
        tests++;
        if (scan_trace[2] !== d) begin
            fails++; $display("FAIL scan_word got %h want %h", scan_trace[2], d);
        end
        tests++;
        if (tree_eval(tree_lut, 8'h01) !== 1'b1 || tree_eval(tree_lut, 8'h03) !== 1'b0) begin
            fails++; $display("FAIL xor_eval got %b%b want 10",
                              tree_eval(tree_lut, 8'h01), tree_eval(tree_lut, 8'h03));
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        int w;
        a = W'($urandom);
        b = W'($urandom);
        run_load(a, 1'b0, b, 1'b1, LSER, w);
        for (int c = 1; c <= LSER; c++) begin
            tests++;
            if (trace[c] !== exp_ctrl(c, a, 1'b0)) begin
                fails++; $display("FAIL b2b_first %0d got %b want %b", c, trace[c], exp_ctrl(c, a, 1'b0));
            end
        end
        run_load(b, 1'b0, '0, 1'b0, LSER + 1, w);
        tests++;
        if (w !== 0) begin
            fails++; $display("FAIL b2b_accept got wait %0d want 0", w);
        end
        for (int c = 1; c <= LSER + 1; c++) begin
            tests++;
            if (trace[c] !== exp_ctrl(c, b, 1'b0)) begin
                fails++; $display("FAIL b2b_second %0d got %b want %b", c, trace[c], exp_ctrl(c, b, 1'b0));
            end
        end
        tests++;
        if (tree_lut !== b) begin
            fails++; $display("FAIL b2b_tree got %h want %h", tree_lut, b);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        logic s;
        int w, L;
        for (int it = 0; it < 12; it++) begin
            d = W'($urandom);
            s = 1'($urandom);
            L = s ? LSCAN : LSER;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_load(d, s, '0, 1'b0, L + 1, w);
            for (int c = 1; c <= L + 1; c++) begin
                tests++;
                if (trace[c] !== exp_ctrl(c, d, s)) begin
                    fails++; $display("FAIL rand_cycle %0d got %b want %b", c, trace[c], exp_ctrl(c, d, s));
                end
            end
            tests++;
            if (tree_lut !== d || w > 199) begin
                fails++; $display("FAIL rand_tree got %h want %h", tree_lut, d);
            end
`ifdef PLT_LOADER_READBACK_EN
            tests++;
            if (ve_trace[L] !== 1'b0) begin
                fails++; $display("FAIL rand_verify got %b want 0", ve_trace[L]);
            end
`endif
        end
    endtask

`ifdef PLT_LOADER_READBACK_EN
    task automatic test_verify();
        logic [W-1:0] d;
        int w;
        d = W'($urandom) & ~(W'(1) << 4);
        stuck5 = 1'b1;
        run_load(d, 1'b0, '0, 1'b0, LSER + 1, w);
        tests++;
        if (ve_trace[LSER] !== 1'b1 || ve_trace[LSER + 1] !== 1'b1) begin
            fails++; $display("FAIL verify_serial got %b want 1", ve_trace[LSER]);
        end
        d = W'($urandom) & ~(W'(1) << 5);
        run_load(d, 1'b1, '0, 1'b0, LSCAN, w);
        tests++;
        if (ve_trace[1] !== 1'b0 || ve_trace[LSCAN] !== 1'b1) begin
            fails++; $display("FAIL verify_scan got %b%b want 01", ve_trace[1], ve_trace[LSCAN]);
        end
        stuck5 = 1'b0;
        run_load(d, 1'b0, '0, 1'b0, LSER, w);
        tests++;
        if (ve_trace[LSER] !== 1'b0) begin
            fails++; $display("FAIL verify_clean got %b want 0", ve_trace[LSER]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_serial_fixed();
        test_e2e_and();
        test_scan_xor();
        test_back_to_back();
        test_random();
`ifdef PLT_LOADER_READBACK_EN
        test_verify();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
